// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI bridge: descriptor layout,
// transaction-issuer FSM states and AXI encodings.
package apb2axi_pkg;

  localparam int TAG_W           = 4;
  localparam int AXI_ADDR_W      = 32;
  localparam int MAX_OUTSTANDING = 4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic                  is_write;
  } directory_entry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_AR = 2'd1,
    ISSUE_AW = 2'd2
  } txn_state_e;

endpackage

// File: rtl/apb2axi_outstanding_cnt.sv
// Outstanding-request counter: +1 on issue, -1 on completion, sticky error
// when a completion arrives with nothing outstanding.
module apb2axi_outstanding_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: count <= count + ONE;
        2'b01: begin
          if (count == '0) err   <= 1'b1;
          else             count <= count - ONE;
        end
        default: ;  // idle, or issue and completion cancel out
      endcase
    end
  end

endmodule

// File: rtl/apb2axi_txn_mgr.sv
// Transaction issuer: pops one descriptor at a time from the directory and
// presents it on AR or AW, gating pops on per-direction outstanding limits.
module apb2axi_txn_mgr
  import apb2axi_pkg::*;
#(
  parameter int TAG_W_P           = TAG_W,
  parameter int ADDR_W_P          = AXI_ADDR_W,
  parameter int MAX_OUTSTANDING_P = MAX_OUTSTANDING,
  parameter int CNT_W             = $clog2(MAX_OUTSTANDING_P + 1)
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                dir_pop_valid,
  input  directory_entry_t    dir_pop_entry,
  input  logic [TAG_W_P-1:0]  dir_pop_tag,
  output logic                dir_pop_ready,
  output logic                ar_valid,
  input  logic                ar_ready,
  output logic [TAG_W_P-1:0]  ar_id,
  output logic [ADDR_W_P-1:0] ar_addr,
  output logic [7:0]          ar_len,
  output logic [2:0]          ar_size,
  output logic [1:0]          ar_burst,
  output logic                aw_valid,
  input  logic                aw_ready,
  output logic [TAG_W_P-1:0]  aw_id,
  output logic [ADDR_W_P-1:0] aw_addr,
  output logic [7:0]          aw_len,
  output logic [2:0]          aw_size,
  output logic [1:0]          aw_burst,
  input  logic                rd_done,
  input  logic                wr_done,
  output logic [CNT_W-1:0]    rd_outstanding,
  output logic [CNT_W-1:0]    wr_outstanding,
  output logic                busy,
  output logic                cnt_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING_P);

  txn_state_e          state, next_state;
  logic                pop, slot_free, ar_hs, aw_hs;
  logic                rd_err, wr_err;
  logic [TAG_W_P-1:0]  hold_tag;
  logic [ADDR_W_P-1:0] hold_addr;
  logic [7:0]          hold_len;
  logic [2:0]          hold_size;

  // Registered counts only: a same-cycle completion frees its slot next cycle.
  assign slot_free     = dir_pop_entry.is_write ? (wr_outstanding < MAX_CNT)
                                                : (rd_outstanding < MAX_CNT);
  assign dir_pop_ready = !preset && (state == IDLE) && slot_free;
  assign pop           = dir_pop_valid && dir_pop_ready;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    ar_hs      = 1'b0;
    aw_hs      = 1'b0;
    case (state)
      IDLE:     if (pop) next_state = dir_pop_entry.is_write ? ISSUE_AW : ISSUE_AR;
      ISSUE_AR: if (ar_ready) begin
                  ar_hs      = 1'b1;
                  next_state = IDLE;
                end
      ISSUE_AW: if (aw_ready) begin
                  aw_hs      = 1'b1;
                  next_state = IDLE;
                end
      default:  next_state = IDLE;
    endcase
  end

  // Holding register only loads on a pop, so payload is frozen while valid.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      hold_tag  <= '0;
      hold_addr <= '0;
      hold_len  <= '0;
      hold_size <= '0;
    end else if (pop) begin
      hold_tag  <= dir_pop_tag;
      hold_addr <= ADDR_W_P'(dir_pop_entry.addr);
      hold_len  <= dir_pop_entry.len;
      hold_size <= dir_pop_entry.size;
    end
  end

  assign ar_valid = (state == ISSUE_AR);
  assign ar_id    = hold_tag;
  assign ar_addr  = hold_addr;
  assign ar_len   = hold_len;
  assign ar_size  = hold_size;
  assign ar_burst = AXI_BURST_INCR;

  assign aw_valid = (state == ISSUE_AW);
  assign aw_id    = hold_tag;
  assign aw_addr  = hold_addr;
  assign aw_len   = hold_len;
  assign aw_size  = hold_size;
  assign aw_burst = AXI_BURST_INCR;

  apb2axi_outstanding_cnt #(.CNT_W(CNT_W)) u_rd_cnt (
    .clk   (pclk),
    .rst   (preset),
    .inc   (ar_hs),
    .dec   (rd_done),
    .count (rd_outstanding),
    .err   (rd_err)
  );

  apb2axi_outstanding_cnt #(.CNT_W(CNT_W)) u_wr_cnt (
    .clk   (pclk),
    .rst   (preset),
    .inc   (aw_hs),
    .dec   (wr_done),
    .count (wr_outstanding),
    .err   (wr_err)
  );

  assign cnt_err = rd_err || wr_err;
  assign busy    = (state != IDLE) || (rd_outstanding != '0) || (wr_outstanding != '0);

endmodule

// File: tb/tb_apb2axi_txn_mgr.sv
// Directed bench for apb2axi_txn_mgr: a monitor scores every AR/AW handshake
// against queued expectations while the main thread checks state and counters.
module tb_apb2axi_txn_mgr;
  import apb2axi_pkg::*;

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef struct {
    logic [TAG_W-1:0]      id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
  } exp_t;

  logic                  pclk = 1'b0;
  logic                  preset = 1'b1;
  logic                  dir_pop_valid = 1'b0;
  directory_entry_t      dir_pop_entry = '0;
  logic [TAG_W-1:0]      dir_pop_tag = '0;
  logic                  dir_pop_ready;
  logic                  ar_valid, aw_valid;
  logic                  ar_ready = 1'b0, aw_ready = 1'b0;
  logic [TAG_W-1:0]      ar_id, aw_id;
  logic [AXI_ADDR_W-1:0] ar_addr, aw_addr;
  logic [7:0]            ar_len, aw_len;
  logic [2:0]            ar_size, aw_size;
  logic [1:0]            ar_burst, aw_burst;
  logic                  rd_done = 1'b0, wr_done = 1'b0;
  logic [CNT_W-1:0]      rd_outstanding, wr_outstanding;
  logic                  busy, cnt_err;

  int   checks = 0;
  int   failures = 0;
  exp_t ar_q[$];
  exp_t aw_q[$];

  apb2axi_txn_mgr dut (
    .pclk           (pclk),
    .preset         (preset),
    .dir_pop_valid  (dir_pop_valid),
    .dir_pop_entry  (dir_pop_entry),
    .dir_pop_tag    (dir_pop_tag),
    .dir_pop_ready  (dir_pop_ready),
    .ar_valid       (ar_valid),
    .ar_ready       (ar_ready),
    .ar_id          (ar_id),
    .ar_addr        (ar_addr),
    .ar_len         (ar_len),
    .ar_size        (ar_size),
    .ar_burst       (ar_burst),
    .aw_valid       (aw_valid),
    .aw_ready       (aw_ready),
    .aw_id          (aw_id),
    .aw_addr        (aw_addr),
    .aw_len         (aw_len),
    .aw_size        (aw_size),
    .aw_burst       (aw_burst),
    .rd_done        (rd_done),
    .wr_done        (wr_done),
    .rd_outstanding (rd_outstanding),
    .wr_outstanding (wr_outstanding),
    .busy           (busy),
    .cnt_err        (cnt_err)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic present(input logic wr, input logic [TAG_W-1:0] tag,
                         input logic [AXI_ADDR_W-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size);
    dir_pop_valid          = 1'b1;
    dir_pop_tag            = tag;
    dir_pop_entry.addr     = addr;
    dir_pop_entry.len      = len;
    dir_pop_entry.size     = size;
    dir_pop_entry.is_write = wr;
    #1;
  endtask

  // Pop the presented entry at the next edge and queue its expected request.
  task automatic accept();
    exp_t e;
    e.id   = dir_pop_tag;
    e.addr = dir_pop_entry.addr;
    e.len  = dir_pop_entry.len;
    e.size = dir_pop_entry.size;
    if (dir_pop_entry.is_write) aw_q.push_back(e);
    else                        ar_q.push_back(e);
    tick();
    dir_pop_valid = 1'b0;
  endtask

  // Monitor: scores each handshake on the falling edge, away from updates.
  always @(negedge pclk) begin
    check("one_valid_at_a_time", {63'd0, ar_valid & aw_valid}, 64'd0);
    if (!preset && ar_valid && ar_ready) begin
      if (ar_q.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = ar_q.pop_front();
        check("ar_id",    64'(ar_id),    64'(e.id));
        check("ar_addr",  64'(ar_addr),  64'(e.addr));
        check("ar_len",   64'(ar_len),   64'(e.len));
        check("ar_size",  64'(ar_size),  64'(e.size));
        check("ar_burst", 64'(ar_burst), 64'(2'b01));
      end
    end
    if (!preset && aw_valid && aw_ready) begin
      if (aw_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = aw_q.pop_front();
        check("aw_id",    64'(aw_id),    64'(e.id));
        check("aw_addr",  64'(aw_addr),  64'(e.addr));
        check("aw_len",   64'(aw_len),   64'(e.len));
        check("aw_size",  64'(aw_size),  64'(e.size));
        check("aw_burst", 64'(aw_burst), 64'(2'b01));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset values, with a valid read offered to prove ready stays low.
    present(1'b0, 4'd3, 32'h1000, 8'd7, 3'd2);
    tick();
    tick();
    check("rst_ar_valid",   64'(ar_valid), 64'd0);
    check("rst_aw_valid",   64'(aw_valid), 64'd0);
    check("rst_pop_ready",  64'(dir_pop_ready), 64'd0);
    check("rst_ar_addr",    64'(ar_addr), 64'd0);
    check("rst_aw_len",     64'(aw_len), 64'd0);
    check("rst_rd_cnt",     64'(rd_outstanding), 64'd0);
    check("rst_wr_cnt",     64'(wr_outstanding), 64'd0);
    check("rst_busy",       64'(busy), 64'd0);
    check("rst_cnt_err",    64'(cnt_err), 64'd0);
    preset = 1'b0;
    dir_pop_valid = 1'b0;
    tick();

    // Read pop: tag 3, addr 0x1000, len 7, size 2.
    ar_ready = 1'b1;
    present(1'b0, 4'd3, 32'h1000, 8'd7, 3'd2);
    check("t1_pop_ready", 64'(dir_pop_ready), 64'd1);
    accept();
    check("t1_ar_valid_n1", 64'(ar_valid), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    tick();
    check("t1_rd_cnt_inc", 64'(rd_outstanding), 64'd1);
    check("t1_ar_valid_drop", 64'(ar_valid), 64'd0);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check("t1_rd_cnt_dec", 64'(rd_outstanding), 64'd0);
    check("t1_idle_busy", 64'(busy), 64'd0);

    // AW back-pressure: aw_ready low for 5 cycles while a read is offered.
    aw_ready = 1'b0;
    present(1'b1, 4'd5, 32'h2000, 8'd3, 3'd3);
    accept();
    present(1'b0, 4'd6, 32'h2100, 8'd1, 3'd1);
    for (int i = 0; i < 5; i++) begin
      check("t2_aw_valid_hold", 64'(aw_valid), 64'd1);
      check("t2_aw_addr_hold",  64'(aw_addr), 64'h2000);
      check("t2_aw_id_hold",    64'(aw_id), 64'd5);
      check("t2_aw_len_hold",   64'(aw_len), 64'd3);
      check("t2_pop_ready_low", 64'(dir_pop_ready), 64'd0);
      check("t2_ar_valid_low",  64'(ar_valid), 64'd0);
      check("t2_wr_cnt_wait",   64'(wr_outstanding), 64'd0);
      tick();
    end
    dir_pop_valid = 1'b0;
    aw_ready = 1'b1;
    tick();
    check("t2_wr_cnt_one", 64'(wr_outstanding), 64'd1);
    tick();
    check("t2_wr_cnt_still_one", 64'(wr_outstanding), 64'd1);
    check("t2_rd_cnt_zero", 64'(rd_outstanding), 64'd0);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check("t2_wr_cnt_back", 64'(wr_outstanding), 64'd0);

    // Read limit: four reads fill the read budget.
    for (int i = 0; i < 4; i++) begin
      present(1'b0, 4'(i), 32'h1100 + 32'(i * 16), 8'(i), 3'd2);
      check("t3_pop_ready_fill", 64'(dir_pop_ready), 64'd1);
      accept();
      check("t3_ar_valid_fill", 64'(ar_valid), 64'd1);
      tick();
    end
    check("t3_rd_cnt_full", 64'(rd_outstanding), 64'd4);
    present(1'b0, 4'd4, 32'h1400, 8'd2, 3'd1);
    check("t3_5th_read_blocked", 64'(dir_pop_ready), 64'd0);
    tick();
    check("t3_no_ar_issue", 64'(ar_valid), 64'd0);
    check("t3_still_blocked", 64'(dir_pop_ready), 64'd0);
    present(1'b1, 4'd9, 32'h2400, 8'd15, 3'd2);
    check("t3_write_allowed", 64'(dir_pop_ready), 64'd1);
    accept();
    check("t3_aw_valid", 64'(aw_valid), 64'd1);
    tick();
    check("t3_wr_cnt_one", 64'(wr_outstanding), 64'd1);
    present(1'b0, 4'd4, 32'h1400, 8'd2, 3'd1);
    rd_done = 1'b1;
    #1;
    check("t3_same_cycle_done_no_slot", 64'(dir_pop_ready), 64'd0);
    tick();
    rd_done = 1'b0;
    #1;
    check("t3_rd_cnt_three", 64'(rd_outstanding), 64'd3);
    check("t3_ready_after_done", 64'(dir_pop_ready), 64'd1);
    accept();
    check("t3_5th_ar_valid", 64'(ar_valid), 64'd1);
    tick();
    check("t3_rd_cnt_refill", 64'(rd_outstanding), 64'd4);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check("t3_wr_cnt_clear", 64'(wr_outstanding), 64'd0);

    // Simultaneous handshake and completion leave the count unchanged.
    rd_done = 1'b1;
    tick();
    tick();
    rd_done = 1'b0;
    check("t4_rd_cnt_two", 64'(rd_outstanding), 64'd2);
    present(1'b0, 4'd7, 32'h1800, 8'd4, 3'd2);
    accept();
    check("t4_ar_valid", 64'(ar_valid), 64'd1);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check("t4_rd_cnt_unchanged", 64'(rd_outstanding), 64'd2);
    check("t4_no_err", 64'(cnt_err), 64'd0);

    // Write underflow sets the sticky error.
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check("t4_wr_cnt_floor", 64'(wr_outstanding), 64'd0);
    check("t4_cnt_err_set", 64'(cnt_err), 64'd1);
    tick();
    tick();
    check("t4_cnt_err_sticky", 64'(cnt_err), 64'd1);

    // Mid-operation reset while stalled in ISSUE_AR with three reads out.
    present(1'b0, 4'd8, 32'h1900, 8'd1, 3'd0);
    accept();
    tick();
    check("t5_rd_cnt_three", 64'(rd_outstanding), 64'd3);
    ar_ready = 1'b0;
    present(1'b0, 4'd10, 32'h1a00, 8'd2, 3'd1);
    accept();
    check("t5_ar_valid_stalled", 64'(ar_valid), 64'd1);
    #2;
    preset = 1'b1;
    ar_q.delete();
    #1;
    check("t5_ar_valid_async_drop", 64'(ar_valid), 64'd0);
    check("t5_rd_cnt_reset", 64'(rd_outstanding), 64'd0);
    check("t5_cnt_err_reset", 64'(cnt_err), 64'd0);
    check("t5_pop_ready_in_rst", 64'(dir_pop_ready), 64'd0);
    tick();
    preset = 1'b0;
    ar_ready = 1'b1;
    present(1'b0, 4'd1, 32'h3000, 8'd15, 3'd1);
    check("t5_pop_ready_after_rst", 64'(dir_pop_ready), 64'd1);
    accept();
    check("t5_ar_valid_after_rst", 64'(ar_valid), 64'd1);
    tick();
    check("t5_rd_cnt_after_rst", 64'(rd_outstanding), 64'd1);

    tick();
    check("ar_queue_drained", 64'(ar_q.size()), 64'd0);
    check("aw_queue_drained", 64'(aw_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
